orb_serializer: RTL and testbench



---
 rtl/orb_pkg.sv | 26 ++
 rtl/orb_bit_timer.sv | 41 ++++
 rtl/orb_serializer.sv | 145 ++++++++++++++
 tb/tb_orb_serializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// Shared definitions for the orbit frame packer and its serializer.
package orb_pkg;

  // Frame RAM geometry
  localparam int unsigned ORB_WORD_W = 12;
  localparam int unsigned ORB_ADDR_W = 11;

  // Default serializer timing and frame size
  localparam int unsigned ORB_BIT_DIV = 8;
  localparam int unsigned ORB_WORDS   = 2048;
  localparam int unsigned ORB_RD_LAT  = 1;

  // Serializer sequencing states
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift
  } orb_state_e;

  // Clock cycles needed to send one complete frame.
  function automatic int unsigned orb_frame_cycles(int unsigned words, int unsigned bit_div);
    return words * ORB_WORD_W * bit_div;
  endfunction

endpackage

// File: rtl/orb_bit_timer.sv
// Bit-period timer for the orbit serializer: divides clk into serial bit slots,
// flags the last cycle of each bit, the high half of the bit clock and the
// cycle at which prefetched RAM data is valid.
module orb_bit_timer
  import orb_pkg::*;
#(
  parameter int unsigned BIT_DIV = ORB_BIT_DIV,
  parameter int unsigned RD_LAT  = ORB_RD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_wrap,
  output logic clk_phase,
  output logic latch_stb
);

  localparam int unsigned DivW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(BIT_DIV / 2);
  localparam logic [DivW-1:0] LatPos  = DivW'(RD_LAT);

  logic [DivW-1:0] div_cnt;

  // Count 0..BIT_DIV-1 while shifting; held at 0 otherwise so each word run
  // starts on a fresh bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!run || (div_cnt == DivLast)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_wrap  = run && (div_cnt == DivLast);
  assign clk_phase = run && (div_cnt < DivHalf);
  assign latch_stb = run && (div_cnt == LatPos);

endmodule

// File: rtl/orb_serializer.sv
// Orbit frame serializer: on every packer bank toggle, reads the bank just
// completed from the frame RAM and sends it as a gapless MSB-first serial
// stream with bit clock, frame sync on the first bit and a done pulse.
module orb_serializer
  import orb_pkg::*;
#(
  parameter int unsigned BIT_DIV = ORB_BIT_DIV,
  parameter int unsigned WORDS   = ORB_WORDS,
  parameter int unsigned RD_LAT  = ORB_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SW,
  input  logic [ORB_WORD_W-1:0] rdData,
  output logic [ORB_ADDR_W-1:0] RdAddr,
  output logic                  RdBank,
  output logic                  orbOut,
  output logic                  orbClk,
  output logic                  frmSync,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LatW-1:0]       LatLast  = LatW'(RD_LAT - 1);
  localparam logic [ORB_ADDR_W-1:0] LastWord = ORB_ADDR_W'(WORDS - 1);
  localparam logic [3:0]            TopBit   = 4'(ORB_WORD_W - 1);

  orb_state_e            state;
  logic [1:0]            sync_sw;
  logic                  old_sw;
  logic                  sw_edge;
  logic [LatW-1:0]       lat_cnt;
  logic [ORB_WORD_W-1:0] shreg;
  logic [ORB_WORD_W-1:0] hold;
  logic [3:0]            bit_cnt;
  logic [ORB_ADDR_W-1:0] word_cnt;
  logic                  shifting;
  logic                  bit_wrap;
  logic                  clk_phase;
  logic                  latch_stb;

  assign shifting = (state == StShift);

  orb_bit_timer #(
    .BIT_DIV (BIT_DIV),
    .RD_LAT  (RD_LAT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (shifting),
    .bit_wrap  (bit_wrap),
    .clk_phase (clk_phase),
    .latch_stb (latch_stb)
  );

  // Bring the asynchronous bank select into clk and remember the last settled level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_sw <= 2'b00;
      old_sw  <= 1'b0;
    end else begin
      sync_sw <= {sync_sw[0], SW};
      old_sw  <= sync_sw[1];
    end
  end

  assign sw_edge = (sync_sw[1] != old_sw);

  // Frame sequencer; a bank toggle takes priority over everything, including
  // the final bit of a frame, so an abort never produces a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StIdle;
      RdAddr   <= '0;
      RdBank   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lat_cnt  <= '0;
      shreg    <= '0;
      hold     <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (sw_edge) begin
        // The packer just left old_sw; that bank is now complete.
        RdBank  <= old_sw;
        RdAddr  <= '0;
        busy    <= 1'b1;
        lat_cnt <= '0;
        state   <= StFetch;
      end else begin
        unique case (state)
          StIdle: begin
            state <= StIdle;
          end
          StFetch: begin
            if (lat_cnt == LatLast) begin
              state <= StLoad;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          StLoad: begin
            shreg    <= rdData;
            bit_cnt  <= TopBit;
            word_cnt <= '0;
            // Point at word 1 now so it is ready well before word 0 runs out.
            RdAddr   <= ORB_ADDR_W'(1);
            state    <= StShift;
          end
          StShift: begin
            if (latch_stb && (bit_cnt == '0)) begin
              hold <= rdData;
            end
            if (bit_wrap) begin
              if (bit_cnt != '0) begin
                shreg   <= {shreg[ORB_WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
              end else if (word_cnt != LastWord) begin
                shreg    <= hold;
                bit_cnt  <= TopBit;
                word_cnt <= word_cnt + 1'b1;
                // Wraps past WORDS-1 once on the last word; that read is discarded.
                RdAddr   <= RdAddr + 1'b1;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= StIdle;
              end
            end
          end
        endcase
      end
    end
  end

  // Serial outputs decode registered state only, so they are quiet outside
  // SHIFT (including the FETCH/LOAD gap) and drop at once on reset.
  assign orbOut  = shifting && shreg[ORB_WORD_W-1];
  assign orbClk  = shifting && clk_phase;
  assign frmSync = shifting && (word_cnt == '0) && (bit_cnt == TopBit);

endmodule

// File: tb/tb_orb_serializer.sv
// Directed bench for orb_serializer with a small two-bank frame RAM model.
module tb_orb_serializer;
  import orb_pkg::*;

  localparam int unsigned BitDiv = 4;
  localparam int unsigned Words  = 4;
  localparam int unsigned RdLat  = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  SW;
  logic [ORB_WORD_W-1:0] rdData;
  logic [ORB_ADDR_W-1:0] RdAddr;
  logic                  RdBank;
  logic                  orbOut;
  logic                  orbClk;
  logic                  frmSync;
  logic                  busy;
  logic                  done;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  logic [ORB_WORD_W-1:0] ram       [0:1][0:2047];
  logic [ORB_WORD_W-1:0] exp_words [0:1][0:3];

  orb_serializer #(
    .BIT_DIV (BitDiv),
    .WORDS   (Words),
    .RD_LAT  (RdLat)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SW      (SW),
    .rdData  (rdData),
    .RdAddr  (RdAddr),
    .RdBank  (RdBank),
    .orbOut  (orbOut),
    .orbClk  (orbClk),
    .frmSync (frmSync),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // One-cycle read latency RAM
  always @(posedge clk) rdData <= ram[RdBank][RdAddr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  // Outputs must stay quiet for n cycles.
  task automatic idle_check(input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || orbClk || orbOut || frmSync || done) act++;
    end
    check_eq("idle_activity", 32'(act), 32'd0);
    check_eq("idle_addr", 32'(RdAddr), 32'd0);
  endtask

  // Wait (bounded) for the first cycle of word 0 and check the lead-in.
  task automatic wait_start(input logic exp_bank);
    int              dones;
    bit              seen;
    logic [10:0]     prev_addr;
    logic [2:0]      prev_q;
    dones     = 0;
    seen      = 1'b0;
    prev_addr = '1;
    prev_q    = '1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (frmSync) begin
        seen = 1'b1;
        break;
      end
      prev_addr = RdAddr;
      prev_q    = {orbClk, orbOut, busy};
    end
    check_eq("start_seen", 32'(seen), 32'd1);
    check_eq("rd_bank", 32'(RdBank), 32'(exp_bank));
    check_eq("load_addr", 32'(prev_addr), 32'd0);
    check_eq("gap_quiet", 32'(prev_q), 32'b001);
    check_eq("no_done_lead_in", 32'(dones), 32'd0);
  endtask

  // Called on cycle 0 of word 0; checks nbits bits cycle by cycle.
  task automatic stream(input int bank, input int nbits);
    int          e_out, e_clk, e_fs, e_busy, e_done, e_addr, w, b;
    logic [11:0] obs;
    logic        eb, ec;
    e_out = 0; e_clk = 0; e_fs = 0; e_busy = 0; e_done = 0; e_addr = 0;
    obs = '0;
    for (int c = 0; c < nbits * 4; c++) begin
      if (c > 0) @(negedge clk);
      w  = c / 48;
      b  = 11 - (c % 48) / 4;
      eb = exp_words[bank][w][b];
      ec = ((c % 4) < 2);
      if (orbOut !== eb) e_out++;
      if (orbClk !== ec) e_clk++;
      if (frmSync !== (c < 4)) e_fs++;
      if (busy !== 1'b1) e_busy++;
      if (done !== 1'b0) e_done++;
      if (RdAddr !== 11'(w + 1)) e_addr++;
      if ((c % 4) == 2) obs = {obs[10:0], orbOut};
      if ((c % 48) == 47) check_eq($sformatf("word%0d", w), 32'(obs), 32'(exp_words[bank][w]));
    end
    check_eq("out_cycles", 32'(e_out), 32'd0);
    check_eq("clk_cycles", 32'(e_clk), 32'd0);
    check_eq("sync_cycles", 32'(e_fs), 32'd0);
    check_eq("busy_cycles", 32'(e_busy), 32'd0);
    check_eq("done_early", 32'(e_done), 32'd0);
    check_eq("addr_cycles", 32'(e_addr), 32'd0);
    if (nbits == 48) begin
      @(negedge clk);
      check_eq("end_state", 32'({done, busy, orbOut, orbClk, frmSync}), 32'b10000);
      @(negedge clk);
      check_eq("done_once", 32'({done, busy}), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_words[0][0] = 12'hA5C; exp_words[0][1] = 12'h123;
    exp_words[0][2] = 12'hFFF; exp_words[0][3] = 12'h000;
    exp_words[1][0] = 12'h5A3; exp_words[1][1] = 12'h0F0;
    exp_words[1][2] = 12'h800; exp_words[1][3] = 12'h001;
    for (int bk = 0; bk < 2; bk++) begin
      for (int a = 0; a < 2048; a++) begin
        ram[bk][a] = (a < 4) ? exp_words[bk][a] : 12'h000;
      end
    end
    rst = 1'b0;
    SW  = 1'b0;
    repeat (3) @(negedge clk);
    phase = "reset";
    check_eq("reset_outs", 32'({RdAddr, RdBank, orbOut, orbClk, frmSync, busy, done}), 32'd0);
    rst = 1'b1;
    idle_check(20);

    phase = "frame0";
    SW = 1'b1;
    wait_start(1'b0);
    stream(0, 48);

    phase = "abort";
    SW = 1'b0;
    wait_start(1'b1);
    stream(1, 20);
    SW = 1'b1;
    wait_start(1'b0);
    stream(0, 48);

    phase = "rst_mid";
    SW = 1'b0;
    wait_start(1'b1);
    stream(1, 26);
    #2 rst = 1'b0;
    #1 check_eq("async_clear", 32'({RdAddr, RdBank, orbOut, orbClk, frmSync, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_check(30);

    phase = "pulse_miss";
    @(negedge clk);
    #1 SW = 1'b1;
    #2 SW = 1'b0;
    idle_check(15);

    phase = "pulse_hit";
    @(negedge clk);
    #3 SW = 1'b1;
    #4 SW = 1'b0;
    wait_start(1'b1);
    stream(1, 48);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
